// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with data-memory request/ack handshake, lane alignment, load extension and MEM/WB register
// Optional feature macro: MEM_MISALIGN_TRAP_EN (adds misalign_err; misaligned half/word accesses are not issued)
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ex_mem_*, ALU_result       EX/MEM register outputs (control, rd, address/ALU value, store data)
//   dmem_req/we/addr/wdata/be  data-memory request (combinational, zero when idle or in reset)
//   dmem_ack, dmem_rdata       data-memory acknowledge and read word (same cycle)
//   mem_stall, bus_err         upstream hold request, sticky timeout flag
//   mem_wb_*                   MEM/WB register outputs and write-back mux
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_mem_RegWrite,
  input  logic              ex_mem_MemtoReg,
  input  logic              ex_mem_us,
  input  logic              ex_mem_MemRead,
  input  logic              ex_mem_MemWrite,
  input  logic [3:0]        ex_mem_byte_en,
  input  logic [4:0]        ex_mem_rd,
  input  logic [31:0]       ALU_result,
  input  logic [31:0]       ex_mem_rd2,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              mem_stall,
  output logic              bus_err,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalign_err,
`endif
  output logic              mem_wb_RegWrite,
  output logic              mem_wb_MemtoReg,
  output logic [4:0]        mem_wb_rd,
  output logic [31:0]       mem_wb_alu,
  output logic [31:0]       mem_wb_rdata,
  output logic [31:0]       mem_wb_result
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;
  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_rw, r_m2r;
  logic [4:0]  r_rd;
  logic [31:0] r_alu, r_rdata;
  logic [1:0]  w_off;
  logic        w_word, w_half, w_mem_op, w_trap, w_op;
  logic        w_idle, w_wait, w_err, w_req;
  logic [3:0]  w_be;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic [31:0] w_ld;
  assign w_off    = ALU_result[1:0];
  assign w_word   = ex_mem_byte_en[3];
  assign w_half   = ~w_word & ex_mem_byte_en[1];
  assign w_mem_op = ex_mem_MemRead | ex_mem_MemWrite;
`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap = w_mem_op & ((w_half & w_off[0]) | (w_word & |w_off));
  logic r_mis;
  assign misalign_err = r_mis;
`else
  assign w_trap = 1'b0;
`endif
  assign w_op   = w_mem_op & ~w_trap;
  assign w_idle = r_state == IDLE;
  assign w_wait = r_state == WAIT;
  assign w_err  = r_state == ERR;
  // rst_n gating keeps the combinational request quiet while reset is held
  assign w_req  = rst_n & ((w_idle & w_op) | w_wait);
  assign w_be   = 4'(ex_mem_byte_en << w_off);
  assign dmem_req   = w_req;
  assign dmem_we    = w_req & ex_mem_MemWrite;
  assign dmem_addr  = w_req ? {ALU_result[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_be    = w_req ? w_be : '0;
  assign dmem_wdata = ~w_req ? '0 : w_word ? ex_mem_rd2 : w_half ? {2{ex_mem_rd2[15:0]}} : {4{ex_mem_rd2[7:0]}};
  assign mem_stall  = rst_n & ((w_idle & w_op & ~dmem_ack) | (w_wait & ~dmem_ack) | w_err);
  assign bus_err    = w_err;
  assign w_b  = dmem_rdata[{w_off, 3'b000} +: 8];
  assign w_h  = dmem_rdata[{w_off[1], 4'b0000} +: 16];
  assign w_ld = w_word ? dmem_rdata : w_half ? {{16{~ex_mem_us & w_h[15]}}, w_h} : {{24{~ex_mem_us & w_b[7]}}, w_b};
  // r_cnt counts WAIT cycles including the current one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (w_idle & w_op & ~dmem_ack) begin
      r_state <= WAIT;
      r_cnt   <= 8'd1;
    end else if (w_wait & dmem_ack) begin
      r_state <= IDLE;
    end else if (w_wait & (r_cnt == 8'(TIMEOUT_CYCLES))) begin
      r_state <= ERR;
    end else if (w_wait) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rw    <= 1'b0;
      r_m2r   <= 1'b0;
      r_rd    <= '0;
      r_alu   <= '0;
      r_rdata <= '0;
    end else if (mem_stall) begin
      r_rw <= 1'b0;
    end else begin
      r_rw    <= ex_mem_RegWrite & ~w_trap;
      r_m2r   <= ex_mem_MemtoReg;
      r_rd    <= ex_mem_rd;
      r_alu   <= ALU_result;
      r_rdata <= w_ld;
    end
  end
`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mis <= 1'b0;
    else r_mis <= ~mem_stall & w_trap;
  end
`endif
  assign mem_wb_RegWrite = r_rw;
  assign mem_wb_MemtoReg = r_m2r;
  assign mem_wb_rd       = r_rd;
  assign mem_wb_alu      = r_alu;
  assign mem_wb_rdata    = r_rdata;
  assign mem_wb_result   = r_m2r ? r_rdata : r_alu;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed vector table plus multi-cycle sequences for mem_access_stage
module tb_mem_access_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        rw, m2r, us, mr, mw, ack;
  logic [3:0]  be;
  logic [4:0]  rd;
  logic [31:0] alu, rd2, rdata;
  logic        dmem_req, dmem_we, mem_stall, bus_err;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        wb_rw, wb_m2r;
  logic [4:0]  wb_rd;
  logic [31:0] wb_alu, wb_rdata, wb_res;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        mis;
`endif
  mem_access_stage #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_mem_RegWrite(rw), .ex_mem_MemtoReg(m2r), .ex_mem_us(us),
    .ex_mem_MemRead(mr), .ex_mem_MemWrite(mw), .ex_mem_byte_en(be),
    .ex_mem_rd(rd), .ALU_result(alu), .ex_mem_rd2(rd2),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(ack), .dmem_rdata(rdata),
    .mem_stall(mem_stall), .bus_err(bus_err),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_err(mis),
`endif
    .mem_wb_RegWrite(wb_rw), .mem_wb_MemtoReg(wb_m2r), .mem_wb_rd(wb_rd),
    .mem_wb_alu(wb_alu), .mem_wb_rdata(wb_rdata), .mem_wb_result(wb_res)
  );
  typedef struct {
    logic rw, m2r, us, mr, mw;
    logic [3:0] be;
    logic [4:0] rd;
    logic [31:0] alu, rd2;
    logic ack;
    logic [31:0] rdata;
    logic e_req, e_we;
    logic [31:0] e_addr;
    logic [3:0] e_be;
    logic [31:0] e_wdata;
    logic e_rw;
    logic [31:0] e_res, e_rdata;
  } vec_t;
  vec_t v[10];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  task automatic drive(input logic i_rw, input logic i_m2r, input logic i_us, input logic i_mr,
                       input logic i_mw, input logic [3:0] i_be, input logic [4:0] i_rd,
                       input logic [31:0] i_alu, input logic [31:0] i_rd2, input logic i_ack,
                       input logic [31:0] i_rdata);
    rw = i_rw; m2r = i_m2r; us = i_us; mr = i_mr; mw = i_mw; be = i_be; rd = i_rd;
    alu = i_alu; rd2 = i_rd2; ack = i_ack; rdata = i_rdata;
  endtask
  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask
  task automatic chk_all_zero(input string n);
    chk({n, "_req"}, 32'(dmem_req), 32'h0);
    chk({n, "_we"}, 32'(dmem_we), 32'h0);
    chk({n, "_addr"}, dmem_addr, 32'h0);
    chk({n, "_be"}, 32'(dmem_be), 32'h0);
    chk({n, "_wdata"}, dmem_wdata, 32'h0);
    chk({n, "_stall"}, 32'(mem_stall), 32'h0);
    chk({n, "_buserr"}, 32'(bus_err), 32'h0);
    chk({n, "_wbrw"}, 32'(wb_rw), 32'h0);
    chk({n, "_wbrd"}, 32'(wb_rd), 32'h0);
    chk({n, "_wbalu"}, wb_alu, 32'h0);
    chk({n, "_wbrdata"}, wb_rdata, 32'h0);
    chk({n, "_wbres"}, wb_res, 32'h0);
  endtask
  initial begin
    int nreq;
    v[0] = '{1'b1,1'b1,1'b0,1'b1,1'b0,4'b1111,5'd1,32'h100,32'h0,1'b1,32'hDEADBEEF, 1'b1,1'b0,32'h100,4'b1111,32'h0,1'b1,32'hDEADBEEF,32'hDEADBEEF};
    v[1] = '{1'b1,1'b1,1'b0,1'b1,1'b0,4'b0001,5'd2,32'h103,32'h0,1'b1,32'h80FF0000, 1'b1,1'b0,32'h100,4'b1000,32'h0,1'b1,32'hFFFFFF80,32'hFFFFFF80};
    v[2] = '{1'b1,1'b1,1'b1,1'b1,1'b0,4'b0001,5'd2,32'h103,32'h0,1'b1,32'h80FF0000, 1'b1,1'b0,32'h100,4'b1000,32'h0,1'b1,32'h00000080,32'h00000080};
    v[3] = '{1'b1,1'b1,1'b0,1'b1,1'b0,4'b0011,5'd3,32'h22,32'h0,1'b1,32'h80011234, 1'b1,1'b0,32'h20,4'b1100,32'h0,1'b1,32'hFFFF8001,32'hFFFF8001};
    v[4] = '{1'b1,1'b1,1'b1,1'b1,1'b0,4'b0011,5'd4,32'h20,32'h0,1'b1,32'h8001F234, 1'b1,1'b0,32'h20,4'b0011,32'h0,1'b1,32'h0000F234,32'h0000F234};
    v[5] = '{1'b0,1'b0,1'b0,1'b0,1'b1,4'b0001,5'd5,32'h41,32'h11223344,1'b1,32'h0, 1'b1,1'b1,32'h40,4'b0010,32'h44444444,1'b0,32'h41,32'h0};
    v[6] = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'b0000,5'd7,32'h12345678,32'h0,1'b0,32'h0, 1'b0,1'b0,32'h0,4'b0000,32'h0,1'b1,32'h12345678,32'h0};
    v[7] = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'b0000,5'd8,32'hFFFF0000,32'h0,1'b1,32'h0, 1'b0,1'b0,32'h0,4'b0000,32'h0,1'b1,32'hFFFF0000,32'h0};
    v[8] = '{1'b0,1'b0,1'b0,1'b1,1'b1,4'b1111,5'd0,32'h8,32'hCAFEF00D,1'b1,32'h0, 1'b1,1'b1,32'h8,4'b1111,32'hCAFEF00D,1'b0,32'h8,32'h0};
    v[9] = '{1'b1,1'b1,1'b0,1'b1,1'b0,4'b0011,5'd9,32'h107,32'h0,1'b1,32'h7FFF0000, 1'b1,1'b0,32'h104,4'b1000,32'h0,1'b1,32'h00007FFF,32'h00007FFF};
    idle();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(v[i].rw, v[i].m2r, v[i].us, v[i].mr, v[i].mw, v[i].be, v[i].rd, v[i].alu, v[i].rd2, v[i].ack, v[i].rdata);
      #1;
      chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'(v[i].e_req));
      chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(v[i].e_we));
      chk($sformatf("v%0d_addr", i), dmem_addr, v[i].e_addr);
      chk($sformatf("v%0d_be", i), 32'(dmem_be), 32'(v[i].e_be));
      chk($sformatf("v%0d_wdata", i), dmem_wdata, v[i].e_wdata);
      chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wbrw", i), 32'(wb_rw), 32'(v[i].e_rw));
      chk($sformatf("v%0d_wbrd", i), 32'(wb_rd), 32'(v[i].rd));
      chk($sformatf("v%0d_wbres", i), wb_res, v[i].e_res);
      chk($sformatf("v%0d_wbrdata", i), wb_rdata, v[i].e_rdata);
    end
    // halfword store acknowledged in its fourth request cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, 5'd5, 32'h22, 32'h1234ABCD, i == 3, 32'h0);
      #1;
      chk($sformatf("hs%0d_req", i), 32'(dmem_req), 32'h1);
      chk($sformatf("hs%0d_we", i), 32'(dmem_we), 32'h1);
      chk($sformatf("hs%0d_addr", i), dmem_addr, 32'h20);
      chk($sformatf("hs%0d_be", i), 32'(dmem_be), 32'hC);
      chk($sformatf("hs%0d_wdata", i), dmem_wdata, 32'hABCDABCD);
      chk($sformatf("hs%0d_stall", i), 32'(mem_stall), (i < 3) ? 32'h1 : 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("hs%0d_wbrw", i), 32'(wb_rw), 32'h0);
      chk($sformatf("hs%0d_wbalu", i), wb_alu, (i < 3) ? 32'h107 : 32'h22);
    end
    @(negedge clk);
    idle();
    #1;
    chk("hs_noreissue_req", 32'(dmem_req), 32'h0);
    chk("hs_noreissue_stall", 32'(mem_stall), 32'h0);
    // back-to-back zero-wait loads
    nreq = 0;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 5'd3, 32'h0, 32'h0, 1'b1, 32'h11111111);
    #1;
    nreq += int'(dmem_req);
    chk("b2b0_stall", 32'(mem_stall), 32'h0);
    @(posedge clk);
    #1;
    chk("b2b0_wbrd", 32'(wb_rd), 32'd3);
    chk("b2b0_wbres", wb_res, 32'h11111111);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 5'd4, 32'h4, 32'h0, 1'b1, 32'h22222222);
    #1;
    nreq += int'(dmem_req);
    chk("b2b1_addr", dmem_addr, 32'h4);
    @(posedge clk);
    #1;
    chk("b2b1_wbrw", 32'(wb_rw), 32'h1);
    chk("b2b1_wbrd", 32'(wb_rd), 32'd4);
    chk("b2b1_wbres", wb_res, 32'h22222222);
    @(negedge clk);
    idle();
    #1;
    nreq += int'(dmem_req);
    chk("b2b_reqcount", 32'(nreq), 32'd2);
    @(posedge clk);
    #1;
    chk("b2b2_wbrw", 32'(wb_rw), 32'h0);
    // unacknowledged load: one IDLE cycle plus four WAIT cycles, then ERR
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 5'd6, 32'h200, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("to%0d_req", i), 32'(dmem_req), 32'h1);
      chk($sformatf("to%0d_stall", i), 32'(mem_stall), 32'h1);
      chk($sformatf("to%0d_buserr", i), 32'(bus_err), 32'h0);
      @(negedge clk);
    end
    ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("err%0d_req", i), 32'(dmem_req), 32'h0);
      chk($sformatf("err%0d_buserr", i), 32'(bus_err), 32'h1);
      chk($sformatf("err%0d_stall", i), 32'(mem_stall), 32'h1);
      @(posedge clk);
      #1;
      chk($sformatf("err%0d_wbrw", i), 32'(wb_rw), 32'h0);
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("errreset");
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    chk("postrst_req", 32'(dmem_req), 32'h0);
    @(posedge clk);
    #1;
    chk("postrst_buserr", 32'(bus_err), 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 5'd10, 32'h300, 32'h0, 1'b1, 32'h5A5A5A5A);
    #1;
    chk("postrst_ld_req", 32'(dmem_req), 32'h1);
    chk("postrst_ld_stall", 32'(mem_stall), 32'h0);
    @(posedge clk);
    #1;
    chk("postrst_ld_wbrw", 32'(wb_rw), 32'h1);
    chk("postrst_ld_wbrdata", wb_rdata, 32'h5A5A5A5A);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
